// File: rtl/adder_issue_pkg.sv
// Shared types and widths for the adder issue buffer.
// Physical register address width is 5+RB.
package adder_issue_pkg;

  localparam int RB  = 2;
  localparam int PW  = 5 + RB;
  localparam int NPR = 32 * (2 ** RB);

  localparam int ADDER_DISPAT_DW   = 2 + 3 * PW + 64 + 2;
  localparam int ADDER_EXEPARAM_DW = 2 + PW + 64 + 64 + 1;

  typedef logic [PW-1:0] paddr_t;

  typedef struct packed {
    logic        add;
    logic        sub;
    paddr_t      rd0;
    paddr_t      rs1;
    paddr_t      rs2;
    logic [63:0] imm;
    logic        use_imm;
    logic        is32;
  } dispat_t;

  typedef struct packed {
    logic        add;
    logic        sub;
    paddr_t      rd0;
    logic [63:0] op1;
    logic [63:0] op2;
    logic        is32;
  } exeparam_t;

endpackage

// File: rtl/adder_issue_lowbit_sel.sv
// Lowest-set-bit one-hot select with a found flag.
// Used for free-slot and eligible-entry selection.
module lowbit_sel #(
  parameter int DP = 4
) (
  input  logic [DP-1:0] req,
  output logic [DP-1:0] oh,
  output logic          found
);

  // Two's complement trick isolates the lowest set bit.
  assign oh    = req & (~req + DP'(1));
  assign found = |req;

endmodule

// File: rtl/adder_issue.sv
// Issue buffer feeding the integer adder: waits for source writeback,
// reads the regfile and registers one packet per cycle.
import adder_issue_pkg::*;

module adder_issue #(
  parameter int DP = 4
) (
  input  logic                         CLK,
  input  logic                         RSTn,
  input  logic                         adder_dispat_vaild,
  output logic                         adder_dispat_ready,
  input  logic [ADDER_DISPAT_DW-1:0]   adder_dispat_info,
  input  logic [NPR-1:0]               wbLog_qout,
  output logic [PW-1:0]                rs1_addr,
  input  logic [63:0]                  rs1_data,
  output logic [PW-1:0]                rs2_addr,
  input  logic [63:0]                  rs2_data,
  input  logic                         flush,
  output logic                         adder_exeparam_vaild,
  output logic [ADDER_EXEPARAM_DW-1:0] adder_exeparam
);

  logic [DP-1:0] valid_q, valid_d;
  dispat_t       ent_q [DP];
  dispat_t       ent_d [DP];
  logic          exe_vld_q, exe_vld_d;
  exeparam_t     exe_q, exe_d;

  dispat_t       din;
  dispat_t       sel;
  logic [DP-1:0] free_oh, elig, sel_oh;
  logic          free_found, sel_found, accept;

  assign din = dispat_t'(adder_dispat_info);

  always_comb begin
    elig = '0;
    for (int i = 0; i < DP; i++) begin
      elig[i] = valid_q[i]
              && wbLog_qout[ent_q[i].rs1]
              && (ent_q[i].use_imm || wbLog_qout[ent_q[i].rs2]);
    end
  end

  lowbit_sel #(.DP(DP)) u_free (
    .req   (~valid_q),
    .oh    (free_oh),
    .found (free_found)
  );

  lowbit_sel #(.DP(DP)) u_sel (
    .req   (elig),
    .oh    (sel_oh),
    .found (sel_found)
  );

  assign adder_dispat_ready = free_found;
  assign accept = adder_dispat_vaild && free_found;

  always_comb begin
    sel = '0;
    for (int i = 0; i < DP; i++) begin
      if (sel_oh[i]) sel = ent_q[i];
    end
  end

  assign rs1_addr = sel.rs1;
  assign rs2_addr = sel.rs2;

  always_comb begin
    valid_d   = valid_q;
    ent_d     = ent_q;
    exe_d     = exe_q;
    exe_vld_d = sel_found && !flush;

    if (sel_found) valid_d = valid_d & ~sel_oh;

    if (accept) begin
      valid_d = valid_d | free_oh;
      for (int i = 0; i < DP; i++) begin
        if (free_oh[i]) ent_d[i] = din;
      end
    end

    // Flush wins over both dispatch and issue.
    if (flush) valid_d = '0;

    if (exe_vld_d) begin
      exe_d.add  = sel.add;
      exe_d.sub  = sel.sub;
      exe_d.rd0  = sel.rd0;
      exe_d.op1  = rs1_data;
      exe_d.op2  = sel.use_imm ? sel.imm : rs2_data;
      exe_d.is32 = sel.is32;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      valid_q   <= '0;
      exe_vld_q <= 1'b0;
      exe_q     <= '0;
      for (int i = 0; i < DP; i++) ent_q[i] <= '0;
    end else begin
      valid_q   <= valid_d;
      exe_vld_q <= exe_vld_d;
      exe_q     <= exe_d;
      for (int i = 0; i < DP; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign adder_exeparam_vaild = exe_vld_q;
  assign adder_exeparam       = exe_q;

endmodule

// File: tb/tb_adder_issue.sv
// Directed bench for adder_issue with a packet scoreboard.
// Regfile modelled as a random-filled array read combinationally.
import adder_issue_pkg::*;

module tb_adder_issue;

  logic                         CLK;
  logic                         RSTn;
  logic                         adder_dispat_vaild;
  logic                         adder_dispat_ready;
  logic [ADDER_DISPAT_DW-1:0]   adder_dispat_info;
  logic [NPR-1:0]               wbLog_qout;
  logic [PW-1:0]                rs1_addr;
  logic [63:0]                  rs1_data;
  logic [PW-1:0]                rs2_addr;
  logic [63:0]                  rs2_data;
  logic                         flush;
  logic                         adder_exeparam_vaild;
  logic [ADDER_EXEPARAM_DW-1:0] adder_exeparam;

  logic [63:0] rf [NPR];
  exeparam_t   sb [$];
  int          passed = 0;
  int          failed = 0;

  adder_issue #(.DP(4)) dut (
    .CLK                  (CLK),
    .RSTn                 (RSTn),
    .adder_dispat_vaild   (adder_dispat_vaild),
    .adder_dispat_ready   (adder_dispat_ready),
    .adder_dispat_info    (adder_dispat_info),
    .wbLog_qout           (wbLog_qout),
    .rs1_addr             (rs1_addr),
    .rs1_data             (rs1_data),
    .rs2_addr             (rs2_addr),
    .rs2_data             (rs2_data),
    .flush                (flush),
    .adder_exeparam_vaild (adder_exeparam_vaild),
    .adder_exeparam       (adder_exeparam)
  );

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exeparam_t mkexp(input logic a, s, input int rd,
      r1, r2, input logic [63:0] im, input logic ui, i32);
    exeparam_t e;
    e.add  = a;
    e.sub  = s;
    e.rd0  = PW'(rd);
    e.op1  = rf[r1];
    e.op2  = ui ? im : rf[r2];
    e.is32 = i32;
    return e;
  endfunction

  task automatic cyc();
    exeparam_t e;
    @(posedge CLK);
    #1;
    if (adder_exeparam_vaild === 1'b1) begin
      chk("issue_expected", 256'(sb.size() != 0), 256'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("issue_pkt", 256'(adder_exeparam), 256'(e));
      end
    end
  endtask

  task automatic disp(input logic a, s, input int rd, r1, r2,
                      input logic [63:0] im, input logic ui, i32);
    dispat_t d;
    d.add     = a;
    d.sub     = s;
    d.rd0     = PW'(rd);
    d.rs1     = PW'(r1);
    d.rs2     = PW'(r2);
    d.imm     = im;
    d.use_imm = ui;
    d.is32    = i32;
    adder_dispat_info  = d;
    adder_dispat_vaild = 1'b1;
    cyc();
    adder_dispat_vaild = 1'b0;
  endtask

  initial begin
    exeparam_t t1;
    for (int i = 0; i < NPR; i++) rf[i] = {$urandom, $urandom};
    rf[3] = 64'd5;
    rf[4] = 64'd7;
    RSTn = 1'b0;
    adder_dispat_vaild = 1'b0;
    adder_dispat_info  = '0;
    wbLog_qout = '0;
    flush = 1'b0;

    // Reset values
    #2;
    chk("rst_vaild", 256'(adder_exeparam_vaild), 256'(0));
    chk("rst_exeparam", 256'(adder_exeparam), 256'(0));
    #16 RSTn = 1'b1;
    cyc();
    chk("rst_ready", 256'(adder_dispat_ready), 256'(1));

    // 1: single add with ready sources
    wbLog_qout[3] = 1'b1;
    wbLog_qout[4] = 1'b1;
    t1 = '0;
    t1.add = 1'b1;
    t1.rd0 = PW'(9);
    t1.op1 = 64'd5;
    t1.op2 = 64'd7;
    sb.push_back(t1);
    disp(1, 0, 9, 3, 4, 64'h0, 0, 0);
    chk("t1_no_early", 256'(adder_exeparam_vaild), 256'(0));
    chk("t1_rs1_addr", 256'(rs1_addr), 256'(3));
    cyc();
    chk("t1_vaild", 256'(adder_exeparam_vaild), 256'(1));
    chk("t1_ready", 256'(adder_dispat_ready), 256'(1));
    chk("t1_idle_addr", 256'(rs1_addr), 256'(0));
    chk("t1_drain", 256'(sb.size()), 256'(0));
    cyc();
    chk("t1_vaild_off", 256'(adder_exeparam_vaild), 256'(0));

    // 2: fill with unready ops, reject fifth, release entry 2
    for (int i = 0; i < 4; i++) begin
      chk("t2_ready_pre", 256'(adder_dispat_ready), 256'(1));
      disp(1, 0, 10 + i, 20 + i, 40 + i, 64'h0, 0, 0);
    end
    chk("t2_full", 256'(adder_dispat_ready), 256'(0));
    disp(1, 0, 14, 3, 4, 64'h0, 0, 0);
    chk("t2_still_full", 256'(adder_dispat_ready), 256'(0));
    wbLog_qout[22] = 1'b1;
    wbLog_qout[42] = 1'b1;
    sb.push_back(mkexp(1, 0, 12, 22, 42, 64'h0, 0, 0));
    cyc();
    chk("t2_issue", 256'(adder_exeparam_vaild), 256'(1));
    chk("t2_ready_after", 256'(adder_dispat_ready), 256'(1));
    cyc();
    chk("t2_single", 256'(adder_exeparam_vaild), 256'(0));
    chk("t2_drain", 256'(sb.size()), 256'(0));

    // 3: sub with immediate, rs2 not ready
    wbLog_qout[5] = 1'b1;
    sb.push_back(mkexp(0, 1, 17, 5, 60, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1));
    disp(0, 1, 17, 5, 60, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1);
    cyc();
    chk("t3_issue", 256'(adder_exeparam_vaild), 256'(1));
    chk("t3_drain", 256'(sb.size()), 256'(0));

    // 4: entries 0 and 3 eligible together
    wbLog_qout[20] = 1'b1;
    wbLog_qout[40] = 1'b1;
    wbLog_qout[23] = 1'b1;
    wbLog_qout[43] = 1'b1;
    sb.push_back(mkexp(1, 0, 10, 20, 40, 64'h0, 0, 0));
    sb.push_back(mkexp(1, 0, 13, 23, 43, 64'h0, 0, 0));
    cyc();
    chk("t4_first", 256'(adder_exeparam_vaild), 256'(1));
    cyc();
    chk("t4_second", 256'(adder_exeparam_vaild), 256'(1));
    chk("t4_drain", 256'(sb.size()), 256'(0));
    cyc();
    chk("t4_done", 256'(adder_exeparam_vaild), 256'(0));

    // 5: full buffer, all eligible, flush with concurrent dispatch
    for (int i = 0; i < 3; i++) disp(1, 0, 30 + i, 30 + i, 50 + i, 64'h0, 0, 0);
    chk("t5_full", 256'(adder_dispat_ready), 256'(0));
    wbLog_qout = '1;
    flush = 1'b1;
    disp(1, 0, 18, 3, 4, 64'h0, 0, 0);
    flush = 1'b0;
    chk("t5_vaild", 256'(adder_exeparam_vaild), 256'(0));
    chk("t5_ready", 256'(adder_dispat_ready), 256'(1));
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_quiet", 256'(adder_exeparam_vaild), 256'(0));
    end
    flush = 1'b1;
    disp(1, 0, 19, 3, 4, 64'h0, 0, 0);
    flush = 1'b0;
    cyc();
    cyc();
    chk("t5_disp_dropped", 256'(adder_exeparam_vaild), 256'(0));

    // 6: async reset while issuing
    wbLog_qout = '0;
    for (int i = 0; i < 3; i++) disp(1, 0, 24 + i, 60 + i, 70 + i, 64'h0, 0, 0);
    wbLog_qout = '1;
    sb.push_back(mkexp(1, 0, 24, 60, 70, 64'h0, 0, 0));
    cyc();
    chk("t6_issuing", 256'(adder_exeparam_vaild), 256'(1));
    #2 RSTn = 1'b0;
    #1;
    chk("t6_async_vaild", 256'(adder_exeparam_vaild), 256'(0));
    chk("t6_async_pkt", 256'(adder_exeparam), 256'(0));
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_no_stale", 256'(adder_exeparam_vaild), 256'(0));
    end
    chk("t6_ready", 256'(adder_dispat_ready), 256'(1));
    chk("t6_drain", 256'(sb.size()), 256'(0));

    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end

endmodule

// File: doc/adder_issue.md
Name: adder_issue

Overview:
- Issue buffer directly upstream of the integer adder execute unit.
- Holds renamed add/sub micro-ops from dispatch until both source physical registers have been written back.
- Reads operands from the physical register file and drives the adder's registered `adder_exeparam_vaild` / `adder_exeparam` pair, one op per cycle.
- Flushed on branch mispredict or exception.

Parameters:
- DP, 4, number of buffer entries (power of two, 2..16)
- RB, `RB (from define.vh), rename bits per architectural register; physical address width is 5+RB
- DW, `ADDER_EXEPARAM_DW = 2+(5+RB)+64+64+1, width of the issue packet to the adder

Ports:
- CLK  in  1  clock
- RSTn  in  1  asynchronous active-low reset
- adder_dispat_vaild  in  1  dispatch presents an op
- adder_dispat_ready  out  1  buffer can accept (= not full)
- adder_dispat_info  in  2+3*(5+RB)+64+2  packed {add, sub, rd0, rs1, rs2, imm[63:0], use_imm, is32}
- wbLog_qout  in  32*2^RB  per-physical-register written-back flag
- rs1_addr  out  5+RB  regfile read port 1 address
- rs1_data  in  64  regfile read data 1 (combinational)
- rs2_addr  out  5+RB  regfile read port 2 address
- rs2_data  in  64  regfile read data 2 (combinational)
- flush  in  1  pipeline flush
- adder_exeparam_vaild  out  1  issue packet valid (registered)
- adder_exeparam  out  DW  issue packet {add, sub, rd0, op1, op2, is32} (registered)

Behaviour:
- Reset (async, RSTn low):
  - all entry valid bits 0
  - `adder_exeparam_vaild` = 0, `adder_exeparam` = 0
  - `adder_dispat_ready` = 1 after reset release
- Storage:
  - DP entries, each with a valid bit plus the dispatch fields.
  - No ordering state; priority is by index.
- Dispatch:
  - Accepted when `adder_dispat_vaild` && `adder_dispat_ready`.
  - Written into the lowest-index invalid entry; that entry's valid bit is set on the next edge.
  - `adder_dispat_ready` = !(all entries valid), computed from current state only.
  - A slot freed by issue in cycle N is usable from cycle N+1.
- Eligibility, evaluated from registered state only:
  - Entry is eligible when valid && wbLog_qout[rs1] && (use_imm || wbLog_qout[rs2]).
  - An op dispatched in cycle N is first eligible in cycle N+1, even if its sources are already ready.
- Select:
  - The lowest-index eligible entry is selected; at most one per cycle.
  - `rs1_addr` / `rs2_addr` are driven from the selected entry; they are 0 when nothing is selected.
- Issue registers, updated on the edge ending the select cycle:
  - `adder_exeparam_vaild` <= (any eligible) && !flush
  - op1 <= rs1_data
  - op2 <= use_imm ? imm : rs2_data
  - add, sub, rd0, is32 copied from the selected entry
  - The selected entry's valid bit is cleared on the same edge.
  - Latency: ready sources to valid issue packet = 1 cycle.
- No issue in a cycle:
  - `adder_exeparam_vaild` <= 0.
  - `adder_exeparam` holds its previous value (don't-care contents).
- Flush:
  - On the edge, clears every entry valid bit and `adder_exeparam_vaild`.
  - Dispatch in the same cycle is discarded.
  - Flush has priority over dispatch and issue.
- Simultaneous dispatch and issue in the same cycle: both take effect; they always target different entries.
- Width: the stored imm is 64 bit, sign-extended upstream; the block performs no arithmetic.
- The adder consumes every packet unconditionally; there is no backpressure from the adder.

Decomposition:
- Shared define.vh:
  - `ADDER_EXEPARAM_DW`
  - `ADDER_DISPAT_DW`
  - `RB`
  - field-order macros used to pack/unpack both packets
- Sub-module `lowbit_sel #(DP)`:
  - combinational lowest-set-bit one-hot plus found flag
  - instanced twice: free-slot select and eligible-entry select
- Registers use the existing `gen_dffr` flops.

Test Plan:
1. Reset, then dispatch add rd0=9, rs1=3, rs2=4 with both wbLog bits set and rs1_data=5, rs2_data=7. Two cycles after dispatch: vaild=1, add=1, rd0=9, op1=5, op2=7. Buffer then empty, ready=1.
2. Dispatch 4 ops with wbLog bits clear. Ready drops to 0 after the 4th, and a 5th dispatch is not accepted. Set wbLog[rs] for entry 2 only: exactly that op issues, and ready=1 the following cycle.
3. Dispatch sub with use_imm=1, imm=64'hFFFF_FFFF_FFFF_FFFE, is32=1, rs1 ready: issued op2=imm, sub=1, is32=1, and rs2 readiness is ignored.
4. Entries 0 and 3 eligible in the same cycle: entry 0 issues first, entry 3 on the next cycle; vaild stays 1 for 2 consecutive cycles.
5. Full buffer, all eligible, assert flush for one cycle concurrent with a dispatch. The next cycle shows vaild=0 and ready=1, and no issue follows even with wbLog all set.
6. Drop RSTn asynchronously mid-issue, between clock edges: vaild goes 0 immediately; after release no stale op issues.
